// File: rtl/mp3_ui_pkg.sv
// mp3_ui_pkg
// Shared constants for the MP3 UI pixel source: UI colours (8 bits per
// channel, rescaled to COLOR_BITS by the top level), layout windows,
// the pixel region enum and the colour-bar test pattern table.
package mp3_ui_pkg;

    // Which part of the UI a raster position falls into.
    typedef enum logic [2:0] {
        REGION_BG,
        REGION_INDICATOR,
        REGION_PROGRESS,
        REGION_VOLUME,
        REGION_TEST_BARS
    } pixRegion_e;

    // UI colours as 24-bit {R,G,B}.
    localparam logic [23:0] COL_BG    = 24'h000040;
    localparam logic [23:0] COL_PLAY  = 24'h00C000;
    localparam logic [23:0] COL_PAUSE = 24'hC00000;
    localparam logic [23:0] COL_FILL  = 24'hE0E0E0;
    localparam logic [23:0] COL_EMPTY = 24'h404040;

    // Layout windows, inclusive bounds, in screen coordinates.
    localparam logic [15:0] IND_X_MIN  = 16'd300;
    localparam logic [15:0] IND_X_MAX  = 16'd339;
    localparam logic [15:0] IND_Y_MIN  = 16'd200;
    localparam logic [15:0] IND_Y_MAX  = 16'd239;
    localparam logic [15:0] BAR_X_MIN  = 16'd64;
    localparam logic [15:0] BAR_X_MAX  = 16'd575;
    localparam logic [15:0] PROG_Y_MIN = 16'd400;
    localparam logic [15:0] PROG_Y_MAX = 16'd415;
    localparam logic [15:0] VOL_Y_MIN  = 16'd430;
    localparam logic [15:0] VOL_Y_MAX  = 16'd445;

    // Colour bars left to right; each entry is {R,G,B} on/off at full scale.
    localparam logic [0:7][2:0] TEST_BAR_RGB = '{
        3'b111,  // white
        3'b110,  // yellow
        3'b011,  // cyan
        3'b010,  // green
        3'b101,  // magenta
        3'b100,  // red
        3'b001,  // blue
        3'b000   // black
    };

    // True when lo <= v <= hi.
    function automatic logic inWindow(input logic [15:0] v,
                                      input logic [15:0] lo,
                                      input logic [15:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/mp3_ui_raster_counter.sv
// mp3_ui_raster_counter
// Holds the raster position of the next pixel to be loaded into the output
// register. Advances one pixel per load, wrapping at the end of each line
// and frame, and flags the first and last pixel of a frame.
module mp3_ui_raster_counter #(
    parameter int H_RES = 640,
    parameter int V_RES = 480,
    parameter int XW    = $clog2(H_RES),
    parameter int YW    = $clog2(V_RES)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          advance_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic          first_o,
    output logic          last_o
);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;

    // Next position: step x, wrap to the next line, wrap the frame after the last line.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (advance_i) begin
            if (x_q == XW'(H_RES - 1)) begin
                x_d = '0;
                y_d = (y_q == YW'(V_RES - 1)) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    // Position register; reset always restarts the raster at (0,0).
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    assign x_o     = x_q;
    assign y_o     = y_q;
    assign first_o = (x_q == '0) && (y_q == '0);
    assign last_o  = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));

endmodule

// File: rtl/mp3_ui_pixel_source.sv
// mp3_ui_pixel_source
// Streams the MP3 player UI as an Avalon-ST raster with SOP/EOP framing into
// the VGA controller's video sink. The status inputs are captured once per
// frame, when pixel (0,0) is loaded, so no frame ever mixes old and new values.
// Optional feature: defining UI_TEST_PATTERN_EN adds the test_mode input,
// which (captured like the status inputs) replaces the UI with eight
// vertical colour bars.
module mp3_ui_pixel_source #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int COLOR_BITS = 8
) (
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic [7:0]              progress,
    input  logic [3:0]              volume,
    input  logic                    playing,
`ifdef UI_TEST_PATTERN_EN
    input  logic                    test_mode,
`endif
    input  logic                    src_ready,
    output logic                    src_valid,
    output logic [3*COLOR_BITS-1:0] src_data,
    output logic                    src_sop,
    output logic                    src_eop
);

    import mp3_ui_pkg::*;

    localparam int XW    = $clog2(H_RES);
    localparam int YW    = $clog2(V_RES);
    localparam int PIX_W = 3 * COLOR_BITS;

    logic [XW-1:0]    rasterX;
    logic [YW-1:0]    rasterY;
    logic             rasterFirst;
    logic             rasterLast;
    logic             load;

    logic [7:0]       progress_q;
    logic [3:0]       volume_q;
    logic             playing_q;
    logic [7:0]       curProgress;
    logic [3:0]       curVolume;
    logic             curPlaying;

    logic [15:0]      pixX;
    logic [15:0]      pixY;
    pixRegion_e       region;
    logic [15:0]      barOffset;
    logic [PIX_W-1:0] pixel_d;

    logic             valid_q;
    logic [PIX_W-1:0] data_q;
    logic             sop_q;
    logic             eop_q;

`ifdef UI_TEST_PATTERN_EN
    localparam logic [15:0] BAR_WIDTH = 16'(H_RES / 8);
    logic             testMode_q;
    logic             curTestMode;
    logic [2:0]       barIndex;
`endif

    // Rescale an 8-bit channel to COLOR_BITS: chan * 2^COLOR_BITS / 256.
    function automatic logic [COLOR_BITS-1:0] scaleChan(input logic [7:0] chan);
        return COLOR_BITS'({chan, {COLOR_BITS{1'b0}}} >> 8);
    endfunction

    // Convert a 24-bit package colour into the output pixel format.
    function automatic logic [PIX_W-1:0] toPixel(input logic [23:0] rgb);
        return {scaleChan(rgb[23:16]), scaleChan(rgb[15:8]), scaleChan(rgb[7:0])};
    endfunction

    // The output register takes a new pixel whenever it is empty or being accepted.
    assign load = !valid_q || src_ready;

    mp3_ui_raster_counter #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .XW    (XW),
        .YW    (YW)
    ) u_raster (
        .clk_i     (clk_clk),
        .reset_i   (reset_reset),
        .advance_i (load),
        .x_o       (rasterX),
        .y_o       (rasterY),
        .first_o   (rasterFirst),
        .last_o    (rasterLast)
    );

    // Capture the status inputs together with the first pixel of each frame.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            progress_q <= '0;
            volume_q   <= '0;
            playing_q  <= 1'b0;
`ifdef UI_TEST_PATTERN_EN
            testMode_q <= 1'b0;
`endif
        end else if (load && rasterFirst) begin
            progress_q <= progress;
            volume_q   <= volume;
            playing_q  <= playing;
`ifdef UI_TEST_PATTERN_EN
            testMode_q <= test_mode;
`endif
        end
    end

    // Pixel (0,0) is rendered with the values being captured on that same clock.
    assign curProgress = rasterFirst ? progress : progress_q;
    assign curVolume   = rasterFirst ? volume   : volume_q;
    assign curPlaying  = rasterFirst ? playing  : playing_q;
`ifdef UI_TEST_PATTERN_EN
    assign curTestMode = rasterFirst ? test_mode : testMode_q;
    assign barIndex    = 3'(pixX / BAR_WIDTH);
`endif

    assign pixX = 16'(rasterX);
    assign pixY = 16'(rasterY);

    // Classify the next pixel; earlier windows take priority over later ones.
    always_comb begin
        region    = REGION_BG;
        barOffset = '0;
`ifdef UI_TEST_PATTERN_EN
        if (curTestMode) begin
            region = REGION_TEST_BARS;
        end else
`endif
        if (inWindow(pixX, IND_X_MIN, IND_X_MAX) && inWindow(pixY, IND_Y_MIN, IND_Y_MAX)) begin
            region = REGION_INDICATOR;
        end else if (inWindow(pixX, BAR_X_MIN, BAR_X_MAX) && inWindow(pixY, PROG_Y_MIN, PROG_Y_MAX)) begin
            region    = REGION_PROGRESS;
            barOffset = pixX - BAR_X_MIN;
        end else if (inWindow(pixX, BAR_X_MIN, BAR_X_MAX) && inWindow(pixY, VOL_Y_MIN, VOL_Y_MAX)) begin
            region    = REGION_VOLUME;
            barOffset = pixX - BAR_X_MIN;
        end
    end

    // Colour the next pixel; the volume segment index is the offset divided by 32.
    always_comb begin
        pixel_d = toPixel(COL_BG);
        case (region)
            REGION_INDICATOR: pixel_d = curPlaying ? toPixel(COL_PLAY) : toPixel(COL_PAUSE);
            REGION_PROGRESS:  pixel_d = (barOffset < {7'd0, curProgress, 1'b0}) ?
                                        toPixel(COL_FILL) : toPixel(COL_EMPTY);
            REGION_VOLUME:    pixel_d = (barOffset[8:5] < curVolume) ?
                                        toPixel(COL_FILL) : toPixel(COL_EMPTY);
`ifdef UI_TEST_PATTERN_EN
            REGION_TEST_BARS: pixel_d = {{COLOR_BITS{TEST_BAR_RGB[barIndex][2]}},
                                         {COLOR_BITS{TEST_BAR_RGB[barIndex][1]}},
                                         {COLOR_BITS{TEST_BAR_RGB[barIndex][0]}}};
`endif
            default:          pixel_d = toPixel(COL_BG);
        endcase
    end

    // Output register: loads on demand, otherwise holds data and framing stable.
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
        end else if (load) begin
            valid_q <= 1'b1;
            data_q  <= pixel_d;
            sop_q   <= rasterFirst;
            eop_q   <= rasterLast;
        end
    end

    assign src_valid = valid_q;
    assign src_data  = data_q;
    assign src_sop   = sop_q;
    assign src_eop   = eop_q;

endmodule

// File: tb/tb_mp3_ui_pixel_source.sv
// tb_mp3_ui_pixel_source
// Self-checking bench for mp3_ui_pixel_source. A frame-level model tracks the
// index of the pixel that must be on the output and the status captured for
// the current frame; a compare process checks every cycle against it, and
// directed steps pin specific pixels to hand-computed colours.
// Define UI_TEST_PATTERN_EN to also exercise the colour-bar test pattern.
module tb_mp3_ui_pixel_source;

    localparam int H = 640;
    localparam int V = 480;
    localparam int N = H * V;

    localparam logic [23:0] BG    = 24'h000040;
    localparam logic [23:0] PLAY  = 24'h00C000;
    localparam logic [23:0] PAUSE = 24'hC00000;
    localparam logic [23:0] FILL  = 24'hE0E0E0;
    localparam logic [23:0] EMPTY = 24'h404040;
    localparam logic [23:0] BARS [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                         24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    logic        clock = 1'b0;
    logic        reset;
    logic        ready;
    logic [7:0]  progress;
    logic [3:0]  volume;
    logic        playing;
    logic        testMode;
    logic        srcValid;
    logic [23:0] srcData;
    logic        srcSop;
    logic        srcEop;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;
    bit finished   = 1'b0;

    bit modelValid = 1'b0;
    int modelPos   = 0;
    int modelNext  = 0;
    int modelProg  = 0;
    int modelVol   = 0;
    bit modelPlay  = 1'b0;
    bit modelTest  = 1'b0;

    bit monEnable     = 1'b0;
    bit sawSop        = 1'b0;
    int beatsSinceSop = 0;
    int sopIntervals  = 0;
    int eopCount      = 0;

    logic [26:0] streamExp;

    always #5 clock = ~clock;

    mp3_ui_pixel_source #(
        .H_RES      (H),
        .V_RES      (V),
        .COLOR_BITS (8)
    ) dut (
        .clk_clk     (clock),
        .reset_reset (reset),
        .progress    (progress),
        .volume      (volume),
        .playing     (playing),
`ifdef UI_TEST_PATTERN_EN
        .test_mode   (testMode),
`endif
        .src_ready   (ready),
        .src_valid   (srcValid),
        .src_data    (srcData),
        .src_sop     (srcSop),
        .src_eop     (srcEop)
    );

    // What the screen must show at (x,y) for the given frame status.
    function automatic logic [23:0] expectedColor(input int x, input int y, input int prog,
                                                  input int vol, input bit play, input bit tm);
        if (tm) return BARS[x / (H / 8)];
        if (x >= 300 && x <= 339 && y >= 200 && y <= 239) return play ? PLAY : PAUSE;
        if (x >= 64 && x <= 575 && y >= 400 && y <= 415) return ((x - 64) < 2 * prog) ? FILL : EMPTY;
        if (x >= 64 && x <= 575 && y >= 430 && y <= 445) return (((x - 64) / 32) < vol) ? FILL : EMPTY;
        return BG;
    endfunction

    task automatic endBench();
        if (!finished) begin
            finished = 1'b1;
            $display("%0d/%0d checks passed", passCount, checkCount);
            $finish;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (model pixel x=%0d y=%0d)",
                     name, actual, expected, modelPos % H, modelPos / H);
            if (failCount >= 200) endBench();
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic rdy, input logic [7:0] prog,
                                 input logic [3:0] vol, input logic play);
        reset    = rst;
        ready    = rdy;
        progress = prog;
        volume   = vol;
        playing  = play;
    endtask

    // Advance (on negedges) until the model says pixel (x,y) is on the output.
    task automatic waitForPixel(input int x, input int y);
        int target = y * H + x;
        int budget = N + 2000;
        while (!(modelValid && modelPos == target) && budget > 0) begin
            @(negedge clock);
            budget--;
        end
        if (!(modelValid && modelPos == target)) begin
            checkCount++;
            failCount++;
            $display("[TB] FAIL wait_pixel: at model pixel %0d, required pixel %0d", modelPos, target);
            endBench();
        end
    endtask

    // Frame model: which pixel index must be presented, and the status captured with pixel 0.
    always @(posedge clock) begin
        if (reset) begin
            modelValid <= 1'b0;
            modelPos   <= 0;
        end else if (!modelValid || ready) begin
            modelNext = modelValid ? (modelPos + 1) % N : 0;
            modelValid <= 1'b1;
            modelPos   <= modelNext;
            if (modelNext == 0) begin
                modelProg <= int'(progress);
                modelVol  <= int'(volume);
                modelPlay <= playing;
                modelTest <= testMode;
            end
        end
    end

    // Every cycle: valid/sop/eop/data must match the model.
    always @(negedge clock) begin
        if (modelValid)
            streamExp = {1'b1, modelPos == 0, modelPos == N - 1,
                         expectedColor(modelPos % H, modelPos / H, modelProg, modelVol, modelPlay, modelTest)};
        else
            streamExp = '0;
        checkOutput("stream", 32'({srcValid, srcSop, srcEop, srcData}), 32'(streamExp));
    end

    // Beat counter: sops must be exactly one frame of beats apart, eop on the last beat.
    always @(negedge clock) begin
        #1;
        if (monEnable && !reset && srcValid && ready) begin
            if (srcSop) begin
                if (sawSop) begin
                    checkOutput("sop_spacing", beatsSinceSop, N);
                    sopIntervals++;
                end
                sawSop        = 1'b1;
                beatsSinceSop = 1;
            end else begin
                beatsSinceSop++;
            end
            if (srcEop) begin
                eopCount++;
                checkOutput("eop_beat", beatsSinceSop, N);
            end
        end
    end

    initial begin
        testMode = 1'b0;
        applyStimulus(1'b1, 1'b1, 8'd128, 4'd0, 1'b1);

        // Reset held for three cycles: nothing valid.
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checkOutput("reset_valid", 32'(srcValid), 32'd0);
        end
        applyStimulus(1'b0, 1'b1, 8'd128, 4'd0, 1'b1);
        @(negedge clock);
        checkOutput("first_valid", 32'(srcValid), 32'd1);
        checkOutput("first_sop", 32'(srcSop), 32'd1);
        checkOutput("first_data", 32'(srcData), 32'h000040);

        // Irregular ready on line 1.
        waitForPixel(0, 1);
        for (int i = 0; i < 1000; i++) begin
            ready = (i % 3 != 2);
            @(negedge clock);
        end
        ready = 1'b1;

        // Reset in mid-frame, then restart at (0,0).
        waitForPixel(100, 100);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("midreset_valid", 32'(srcValid), 32'd0);
        checkOutput("midreset_data", 32'(srcData), 32'd0);
        @(negedge clock);
        reset     = 1'b0;
        monEnable = 1'b1;
        @(negedge clock);
        checkOutput("restart_valid", 32'(srcValid), 32'd1);
        checkOutput("restart_sop", 32'(srcSop), 32'd1);
        checkOutput("restart_data", 32'(srcData), 32'h000040);

        // Frame 1: progress 128, volume 0, playing.
        waitForPixel(300, 200);
        checkOutput("ind_play", 32'(srcData), 32'h00C000);
        waitForPixel(0, 300);
        applyStimulus(1'b0, 1'b1, 8'd128, 4'd15, 1'b0);

        // Stall mid-line on the progress bar; a skipped pixel would move the fill edge.
        waitForPixel(310, 400);
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            checkOutput("stall_hold", 32'({srcValid, srcSop, srcEop, srcData}), {5'd0, 3'b100, 24'hE0E0E0});
        end
        ready = 1'b1;
        waitForPixel(319, 400);
        checkOutput("prog_fill_edge", 32'(srcData), 32'hE0E0E0);
        waitForPixel(320, 400);
        checkOutput("prog_empty_edge", 32'(srcData), 32'h404040);
        waitForPixel(64, 430);
        checkOutput("vol0_first_seg", 32'(srcData), 32'h404040);
        waitForPixel(639, 479);
        checkOutput("eop_flag", 32'(srcEop), 32'd1);

        // Frame 2: volume 15, paused, captured at the frame boundary.
        waitForPixel(0, 0);
        checkOutput("frame2_sop", 32'(srcSop), 32'd1);
        waitForPixel(300, 200);
        checkOutput("ind_pause", 32'(srcData), 32'hC00000);
        waitForPixel(543, 430);
        checkOutput("vol15_seg14", 32'(srcData), 32'hE0E0E0);
        waitForPixel(575, 430);
        checkOutput("vol15_seg15", 32'(srcData), 32'h404040);
        checkOutput("eop_count", eopCount, 1);
        checkOutput("sop_intervals", sopIntervals, 1);

`ifdef UI_TEST_PATTERN_EN
        // Colour bars selected through test_mode.
        monEnable = 1'b0;
        testMode  = 1'b1;
        reset     = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("tp_white", 32'(srcData), 32'hFFFFFF);
        waitForPixel(80, 0);
        checkOutput("tp_yellow", 32'(srcData), 32'hFFFF00);
        waitForPixel(639, 0);
        checkOutput("tp_black", 32'(srcData), 32'h000000);
`endif

        endBench();
    end

endmodule
